// File: rtl/ram_burst_reader_pkg.sv
// Shared defaults, FSM encoding and buffer sizing for the RAM burst reader.
package ram_burst_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 6;

    // Output buffer depth; the count port needs one extra code for "full".
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Bundle of burst request, RAM read port and output stream signals.
// Stream handshake: a beat transfers on a rising edge where dout_valid and
// dout_ready are both 1; while dout_valid=1 and dout_ready=0, dout holds.
interface ram_burst_reader_if #(
    parameter int DATA_W = ram_burst_pkg::DEF_DATA_W,
    parameter int ADDR_W = ram_burst_pkg::DEF_ADDR_W
);
    import ram_burst_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;
    state_t            dbg_state;

    modport master (
        input  start, base_addr, len, q, dout_ready,
        output read_addr, dout, dout_valid, busy, done, dbg_state
    );

    modport slave (
        output start, base_addr, len, q, dout_ready,
        input  read_addr, dout, dout_valid, busy, done, dbg_state
    );

endinterface

// File: rtl/ram_burst_reader_skid_fifo2.sv
// Two-entry FIFO holding RAM words until the stream consumer accepts them.
module skid_fifo2
    import ram_burst_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          din,
    input  logic                  pop,
    output logic [W-1:0]          dout,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [W-1:0] mem [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Reads a burst of consecutive words from a registered-output RAM and streams
// them out through a 2-entry buffer with valid/ready flow control.
module ram_burst_reader
    import ram_burst_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    ram_burst_reader_if.master bus
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W:0]     issued_cnt;
    logic [ADDR_W:0]     beat_cnt;
    logic                inflight_r;
    logic                burst_done_r;
    logic                zero_done_r;
    logic                accept;
    logic                issue;
    logic                pop;
    logic [2:0]          outstanding;
    logic [DATA_W-1:0]   fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;

    // The done cycle of a real burst still counts as busy, so start is refused there.
    assign accept = (state == ST_IDLE) && bus.start && !burst_done_r;
    assign pop    = !fifo_empty && bus.dout_ready;

    // Words owed to the consumer once this cycle's pop (if any) is taken.
    assign outstanding = {2'b00, inflight_r} + {1'b0, fifo_count} - {2'b00, pop};

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && (bus.len != '0)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                issue = (outstanding < 3'd2) && !(fifo_full && !pop);
                if (issue && (issued_cnt + (ADDR_W+1)'(1) == len_r)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && (beat_cnt + (ADDR_W+1)'(1) == len_r)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr_r       <= '0;
            len_r        <= '0;
            issued_cnt   <= '0;
            beat_cnt     <= '0;
            inflight_r   <= 1'b0;
            burst_done_r <= 1'b0;
            zero_done_r  <= 1'b0;
        end else begin
            state        <= state_nxt;
            inflight_r   <= issue;
            burst_done_r <= (state == ST_DRAIN) && (state_nxt == ST_IDLE);
            zero_done_r  <= accept && (bus.len == '0);
            if (accept) begin
                addr_r     <= bus.base_addr;
                len_r      <= bus.len;
                issued_cnt <= '0;
                beat_cnt   <= '0;
            end else begin
                if (issue) begin
                    addr_r     <= addr_r + ADDR_W'(1);
                    issued_cnt <= issued_cnt + (ADDR_W+1)'(1);
                end
                if (pop) beat_cnt <= beat_cnt + (ADDR_W+1)'(1);
            end
        end
    end

    // A read issued last cycle lands on q now; reset clears the flag so stale data is dropped.
    skid_fifo2 #(.W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_r),
        .din   (bus.q),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.read_addr  = addr_r;
    assign bus.dout       = fifo_dout;
    assign bus.dout_valid = !fifo_empty;
    assign bus.busy       = (state != ST_IDLE) || burst_done_r;
    assign bus.done       = burst_done_r || zero_done_r;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: RAM model, stream scoreboard, summary.
module tb_ram_burst_reader;
  import ram_burst_pkg::*;

  localparam int DW = 8;
  localparam int AW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_burst_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

  ram_burst_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  // Registered-output RAM: q in cycle N+1 reflects read_addr in cycle N.
  logic [DW-1:0] ram [1 << AW];
  always @(posedge clk) bus_if.q <= ram[bus_if.read_addr];

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_dout = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: pops the expected queue on every transferred beat.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(bus_if.dout_valid), 32'd1);
        check("stall_dout_held", 32'(bus_if.dout), 32'(prev_dout));
      end
      if (bus_if.dout_valid && bus_if.dout_ready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("beat_data", 32'(bus_if.dout), 32'(exp_q.pop_front()));
        beat_cnt++;
      end
      if (bus_if.done) done_cnt++;
      prev_stall = bus_if.dout_valid && !bus_if.dout_ready;
      prev_dout  = bus_if.dout;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int base, input int len, input bit expect_data);
    if (expect_data)
      for (int k = 0; k < len; k++) exp_q.push_back(DW'(8'h40 + ((base + k) % 64)));
    bus_if.base_addr = AW'(base);
    bus_if.len       = (AW+1)'(len);
    bus_if.start     = 1'b1;
    tick(1);
    bus_if.start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget, input bit rand_ready);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      if (rand_ready) bus_if.dout_ready = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    check({tag, "_done_count"}, 32'(done_cnt), 32'(target));
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int d0;
    int b0;
    int n;
    int vcnt;

    for (int i = 0; i < 64; i++) ram[i] = DW'(8'h40 + i);
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.base_addr = '0;
    bus_if.len = '0;
    bus_if.dout_ready = 1'b0;
    tick(3);

    check("rst_dout_valid", 32'(bus_if.dout_valid), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_read_addr", 32'(bus_if.read_addr), 32'd0);
    check("rst_dout", 32'(bus_if.dout), 32'd0);
    check("rst_state", 32'(bus_if.dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick(1);

    // Burst base=5 len=4 with ready held: latency, back-to-back beats, done/busy timing.
    bus_if.dout_ready = 1'b1;
    start_burst(5, 4, 1'b1);
    check("t1_busy_after_start", 32'(bus_if.busy), 32'd1);
    lat = 1;
    while (!bus_if.dout_valid && lat < 10) begin
      tick(1);
      lat++;
    end
    check("t1_first_valid_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 4; i++) begin
      check("t1_consecutive_valid", 32'(bus_if.dout_valid), 32'd1);
      tick(1);
    end
    check("t1_done_pulse", 32'(bus_if.done), 32'd1);
    check("t1_busy_in_done", 32'(bus_if.busy), 32'd1);
    check("t1_valid_after_last", 32'(bus_if.dout_valid), 32'd0);
    tick(1);
    check("t1_done_cleared", 32'(bus_if.done), 32'd0);
    check("t1_busy_cleared", 32'(bus_if.busy), 32'd0);
    check("t1_done_count", 32'(done_cnt), 32'd1);
    check("t1_queue_drained", 32'(exp_q.size()), 32'd0);

    // Address wrap 62,63,0,1.
    start_burst(62, 4, 1'b1);
    wait_done("t2_wrap", 2, 50, 1'b0);

    // Full-depth burst with random backpressure.
    start_burst(17, 64, 1'b1);
    wait_done("t3_full_rand", 3, 1000, 1'b1);
    bus_if.dout_ready = 1'b1;
    tick(1);

    // Zero-length burst: one done pulse, never busy, no beats.
    d0 = done_cnt;
    b0 = beat_cnt;
    start_burst(9, 0, 1'b0);
    check("t4_done_pulse", 32'(bus_if.done), 32'd1);
    check("t4_busy_low", 32'(bus_if.busy), 32'd0);
    check("t4_no_valid", 32'(bus_if.dout_valid), 32'd0);
    tick(1);
    check("t4_done_cleared", 32'(bus_if.done), 32'd0);
    check("t4_busy_still_low", 32'(bus_if.busy), 32'd0);
    tick(3);
    check("t4_done_once", 32'(done_cnt), 32'(d0 + 1));
    check("t4_no_beats", 32'(beat_cnt), 32'(b0));

    // Reset after 2 beats of a len=8 burst, then a fresh burst.
    b0 = beat_cnt;
    start_burst(10, 8, 1'b1);
    n = 0;
    while (beat_cnt < b0 + 2 && n < 50) begin
      tick(1);
      n++;
    end
    check("t5_two_beats_seen", 32'(beat_cnt), 32'(b0 + 2));
    rst = 1'b1;
    exp_q.delete();
    d0 = done_cnt;
    tick(1);
    rst = 1'b0;
    check("t5_rst_valid", 32'(bus_if.dout_valid), 32'd0);
    check("t5_rst_busy", 32'(bus_if.busy), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus_if.dout_valid) vcnt++;
      tick(1);
    end
    check("t5_no_valid_after_rst", 32'(vcnt), 32'd0);
    check("t5_no_done_after_rst", 32'(done_cnt), 32'(d0));
    start_burst(0, 2, 1'b1);
    wait_done("t5_after_rst", d0 + 1, 50, 1'b0);

    // Start pulses while busy (mid-burst and in the done cycle) must be ignored.
    d0 = done_cnt;
    start_burst(20, 6, 1'b1);
    tick(2);
    bus_if.base_addr = AW'(40);
    bus_if.len = (AW+1)'(3);
    bus_if.start = 1'b1;
    tick(1);
    bus_if.start = 1'b0;
    n = 0;
    while (!bus_if.done && n < 50) begin
      tick(1);
      n++;
    end
    check("t6_done_reached", 32'(bus_if.done), 32'd1);
    bus_if.start = 1'b1;
    tick(1);
    bus_if.start = 1'b0;
    tick(6);
    check("t6_done_once", 32'(done_cnt), 32'(d0 + 1));
    check("t6_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t6_busy_low", 32'(bus_if.busy), 32'd0);
    check("t6_state_idle", 32'(bus_if.dbg_state), 32'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
